// File: rtl/n4_mux_rr_scheduler.sv
// n4_mux_rr_scheduler: round-robin owner arbitration driving the shared 10:1 mux / 1:10 demux select
module n4_mux_rr_scheduler #(
  parameter int          N_CH     = 10,
  parameter int          MAX_HOLD = 16,
  parameter logic [7:0]  SEL_IDLE = 8'd255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  output logic [N_CH-1:0] grant,
  output logic [7:0]      select,
  output logic            busy,
  output logic            timeout
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t      state;
  logic [15:0] hold_cnt;
  logic [3:0]  last_owner, win, idx;
  logic        hit, drop, rel;
  // descending scan so the nearest requester after last_owner overwrites the others
  always_comb begin
    win = last_owner;
    idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = 4'((int'(last_owner) + k) % N_CH);
      if (req[idx]) win = idx;
    end
  end
  assign hit  = (MAX_HOLD != 0) && (hold_cnt == 16'(MAX_HOLD - 1));
  assign drop = !req[last_owner];
  assign rel  = done || drop || hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      select     <= SEL_IDLE;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 4'd9;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state      <= OWN;
          grant      <= {{(N_CH-1){1'b0}}, 1'b1} << win;
          select     <= 8'(win);
          busy       <= 1'b1;
          hold_cnt   <= '0;
          last_owner <= win;
        end
      end else if (rel) begin
        state    <= IDLE;
        grant    <= '0;
        select   <= SEL_IDLE;
        busy     <= 1'b0;
        hold_cnt <= '0;
        timeout  <= hit && !done && !drop;
      end else begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy == |grant);
  a_sel:    assert property (@(posedge clk) disable iff (rst) busy |-> (select < 8'(N_CH)) && grant[select[3:0]]);
  a_idle:   assert property (@(posedge clk) disable iff (rst) !busy |-> select == SEL_IDLE);
endmodule

// File: tb/tb_n4_mux_rr_scheduler.sv
// tb_n4_mux_rr_scheduler: directed checks of grant order, turnaround, hold limit, abort and reset
module tb_n4_mux_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] req = '0;
  logic       done = 1'b0;
  logic [9:0] grant;
  logic [7:0] select;
  logic       busy, timeout;
  int checks = 0;
  int errors = 0;

  n4_mux_rr_scheduler #(.N_CH(10), .MAX_HOLD(16), .SEL_IDLE(8'd255)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .select(select), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    tick(); tick();
    checks++; if (grant !== 10'h000) begin errors++; $display("FAIL reset_grant got=%h exp=%h", grant, 10'h000); end
    checks++; if (select !== 8'd255) begin errors++; $display("FAIL reset_select got=%0d exp=255", select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 10'h001;
    tick();
    checks++; if (grant !== 10'h001) begin errors++; $display("FAIL single_grant got=%h exp=001", grant); end
    checks++; if (select !== 8'd0) begin errors++; $display("FAIL single_select got=%0d exp=0", select); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
    checks++; if (grant !== 10'h000) begin errors++; $display("FAIL single_rel_grant got=%h exp=000", grant); end
    checks++; if (select !== 8'd255) begin errors++; $display("FAIL single_rel_select got=%0d exp=255", select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_rel_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_g;
    int ch;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 10'h3FF;
    tick();
    for (int n = 0; n < 11; n++) begin
      ch = n % 10;
      exp_g = 10'h001 << ch;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant n=%0d got=%h exp=%h", n, grant, exp_g); end
      checks++; if (select !== 8'(ch)) begin errors++; $display("FAIL rr_select n=%0d got=%0d exp=%0d", n, select, ch); end
      tick();
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_hold n=%0d got=%h exp=%h", n, grant, exp_g); end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (grant !== 10'h000 || busy !== 1'b0) begin errors++; $display("FAIL rr_dead n=%0d got=%h/%b exp=000/0", n, grant, busy); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rr_timeout n=%0d got=%b exp=0", n, timeout); end
      tick();
    end
    req = '0; done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic test_timeout();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 10'h010;
    tick();
    checks++; if (grant !== 10'h010) begin errors++; $display("FAIL to_grant got=%h exp=010", grant); end
    for (int i = 2; i <= 16; i++) begin
      tick();
      checks++; if (grant !== 10'h010 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold cyc=%0d got=%h/%b exp=010/0", i, grant, timeout); end
    end
    tick();
    checks++; if (grant !== 10'h000 || select !== 8'd255) begin errors++; $display("FAIL to_release got=%h/%0d exp=000/255", grant, select); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    tick();
    checks++; if (grant !== 10'h010 || select !== 8'd4) begin errors++; $display("FAIL to_regrant got=%h/%0d exp=010/4", grant, select); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got=%b exp=0", timeout); end
  endtask

  task automatic test_done_at_limit();
    for (int i = 2; i <= 16; i++) tick();
    checks++; if (grant !== 10'h010) begin errors++; $display("FAIL dl_still_owned got=%h exp=010", grant); end
    done = 1'b1;
    tick();
    done = 1'b0; req = '0;
    checks++; if (grant !== 10'h000 || busy !== 1'b0) begin errors++; $display("FAIL dl_release got=%h/%b exp=000/0", grant, busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dl_timeout got=%b exp=0", timeout); end
    tick();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dl_after got=%b/%b exp=0/0", timeout, busy); end
  endtask

  task automatic test_abort();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 10'h080;
    tick();
    checks++; if (grant !== 10'h080 || select !== 8'd7) begin errors++; $display("FAIL ab_grant got=%h/%0d exp=080/7", grant, select); end
    req = 10'h0C4;
    tick();
    checks++; if (grant !== 10'h080) begin errors++; $display("FAIL ab_no_preempt got=%h exp=080", grant); end
    req = 10'h044;
    tick();
    checks++; if (grant !== 10'h000 || timeout !== 1'b0) begin errors++; $display("FAIL ab_release got=%h/%b exp=000/0", grant, timeout); end
    tick();
    checks++; if (grant !== 10'h004 || select !== 8'd2) begin errors++; $display("FAIL ab_wrap got=%h/%0d exp=004/2", grant, select); end
  endtask

  task automatic test_reset_mid_grant();
    done = 1'b1; req = '0;
    tick();
    done = 1'b0; req = 10'h020;
    tick();
    checks++; if (grant !== 10'h020 || select !== 8'd5) begin errors++; $display("FAIL rm_grant got=%h/%0d exp=020/5", grant, select); end
    rst = 1'b1; req = 10'h3FF;
    tick();
    checks++; if (grant !== 10'h000 || select !== 8'd255 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rm_reset got=%h/%0d/%b/%b exp=000/255/0/0", grant, select, busy, timeout); end
    rst = 1'b0;
    tick();
    checks++; if (grant !== 10'h001 || select !== 8'd0) begin errors++; $display("FAIL rm_first got=%h/%0d exp=001/0", grant, select); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_abort();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/n4_mux_rr_scheduler.md
Name: n4_mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 10:1 mux / 1:10 demux datapath pair among 10 requesters.
- Grants ownership to one channel at a time and drives the 8-bit channel select directly.
- Releases ownership on transaction end, request withdrawal, or hold-time limit.
- Sits beside the mux/demux pair in the n4 design; the select output feeds both select inputs unmodified.

Parameters:
- N_CH, 10, number of requesters; fixed at 10 (select encodes 0..9).
- MAX_HOLD, 16, maximum cycles one owner may hold the grant; 0 disables the limit; legal range 0..65535.
- SEL_IDLE, 8'd255, select value driven when no channel owns the path; out of range so mux output and all demux outputs are 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  10  per-channel request; bit i = channel i wants the path.
- done  input  1  owner signals last cycle of its transaction; ignored when no owner.
- grant  output  10  registered one-hot grant; all zero when idle.
- select  output  8  registered owner index 0..9 when busy, else SEL_IDLE.
- busy  output  1  registered; 1 while a channel owns the path.
- timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst=1 at an edge): grant=0, select=SEL_IDLE, busy=0, timeout=0, hold_cnt=0, state=IDLE, last_owner=9, so channel 0 has highest priority first.
- Reset mid-grant takes effect at the same edge and abandons the owner with no timeout pulse.
- States:
  - IDLE: no owner.
  - OWN: one owner; grant, select and busy reflect it.
- IDLE:
  - If req!=0, pick the winner: first set bit searching from (last_owner+1) mod 10 upward, wrapping.
  - At the next edge: state=OWN, grant=one-hot(winner), select=winner, busy=1, hold_cnt=0, last_owner=winner.
  - Latency from req seen in IDLE to grant is 1 cycle.
- OWN: each cycle, evaluate in priority order.
  - (a) done=1: release.
  - (b) req[owner]=0: release, treated as abort.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: release and timeout=1 for the following cycle.
  - Otherwise hold_cnt+=1 (16-bit).
- Release, at the next edge: state=IDLE, grant=0, select=SEL_IDLE, busy=0, hold_cnt=0.
- Turnaround after release:
  - Exactly one dead cycle with grant=0 before any new grant, so the mux never switches sources within a cycle.
  - A waiting requester is granted at the second edge after the releasing cycle.
- Simultaneous release causes: done has priority. done=1 on the hold-limit cycle is a normal release with no timeout pulse. Owner req drop together with the hold limit also gives no timeout.
- Other req bits never affect an active owner; there is no preemption.
- Fairness: with N requesters continuously asserted, each is granted once per N grants, in ascending index order with wrap.
- timeout is 0 in every cycle except the one after a forced release.
- Invariants checked by assertion:
  - grant is zero or one-hot.
  - busy == |grant.
  - When busy, select == index of the set grant bit.
  - When !busy, select == SEL_IDLE.

Test Plan:
- Reset then req=10'b0000000001 → next edge grant=0x001, select=0, busy=1; after done pulse → next edge grant=0, select=255, busy=0.
- req=10'h3FF held, done pulsed every 3rd owned cycle → grant sequence 0,1,2,…,9,0 with one idle cycle between grants; select tracks the index.
- MAX_HOLD=16, req[4] held, done never → grant[4] high exactly 16 cycles, timeout=1 one cycle, then re-grant to 4 after one idle cycle.
- done=1 on the 16th owned cycle (hold limit) → release, timeout stays 0.
- Owner 7 drops req[7] mid-transaction while req[2] is set → release next edge, grant[2] one cycle later, no timeout; last_owner=7 so the search starts at 8 and wraps to 2.
- rst asserted while channel 5 is granted → next edge all outputs at reset values; with req=0x3FF held, first grant after reset is channel 0.
